// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command-frame decoder and its consumers.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  // Command codes understood by the downstream control logic.
  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_READ   = 8'h10;
  localparam logic [7:0] CMD_WRITE  = 8'h20;
  localparam logic [7:0] CMD_STATUS = 8'h30;

  function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, decoded frame and error strobes out, for the command parser.
interface uart_cmd_parser_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic                   pic_mode;
  logic                   byte_valid;
  logic [7:0]             byte_data;
  logic                   busy;
  logic                   frame_valid;
  logic [7:0]             frame_cmd;
  logic [3:0]             frame_len;
  logic [8*MAX_LEN-1:0]   frame_payload;
  logic                   err_chk;
  logic                   err_len;
  logic                   err_timeout;

  modport master (
    output pic_mode, byte_valid, byte_data,
    input  busy, frame_valid, frame_cmd, frame_len, frame_payload,
           err_chk, err_len, err_timeout
  );

  modport slave (
    input  pic_mode, byte_valid, byte_data,
    output busy, frame_valid, frame_cmd, frame_len, frame_payload,
           err_chk, err_len, err_timeout
  );
endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter; expired is high while the count equals TIMEOUT.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT = 5000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 16'(TIMEOUT));

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes SYNC/CMD/LEN/payload/CHK frames from the UART command byte stream.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 8,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT   = 5000
) (
  input  logic              clock_system,
  input  logic              rstn,
  uart_cmd_parser_if.slave  bus
);

  localparam int unsigned PW = 8 * MAX_LEN;

  state_e          state_q, state_d;
  logic [7:0]      wcmd_q, wcmd_d;
  logic [3:0]      wlen_q, wlen_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      sum_q, sum_d;
  logic [PW-1:0]   wbuf_q, wbuf_d;
  logic [7:0]      fcmd_q, fcmd_d;
  logic [3:0]      flen_q, flen_d;
  logic [PW-1:0]   fpay_q, fpay_d;
  logic            fvalid_q, fvalid_d;
  logic            echk_q, echk_d;
  logic            elen_q, elen_d;
  logic            eto_q, eto_d;

  logic accept;
  logic tmr_clear;
  logic tmr_expired;

  assign accept    = bus.byte_valid && !bus.pic_mode;
  assign tmr_clear = accept || bus.pic_mode || (state_q == ST_IDLE);

  uart_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
    .clk     (clock_system),
    .rstn    (rstn),
    .clear   (tmr_clear),
    .enable  (state_q != ST_IDLE),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock_system) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      wcmd_q   <= '0;
      wlen_q   <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      wbuf_q   <= '0;
      fcmd_q   <= '0;
      flen_q   <= '0;
      fpay_q   <= '0;
      fvalid_q <= 1'b0;
      echk_q   <= 1'b0;
      elen_q   <= 1'b0;
      eto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcmd_q   <= wcmd_d;
      wlen_q   <= wlen_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      wbuf_q   <= wbuf_d;
      fcmd_q   <= fcmd_d;
      flen_q   <= flen_d;
      fpay_q   <= fpay_d;
      fvalid_q <= fvalid_d;
      echk_q   <= echk_d;
      elen_q   <= elen_d;
      eto_q    <= eto_d;
    end
  end

  // pic_mode outranks an accepted byte, which outranks the gap timeout.
  always_comb begin
    state_d  = state_q;
    wcmd_d   = wcmd_q;
    wlen_d   = wlen_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    wbuf_d   = wbuf_q;
    fcmd_d   = fcmd_q;
    flen_d   = flen_q;
    fpay_d   = fpay_q;
    fvalid_d = 1'b0;
    echk_d   = 1'b0;
    elen_d   = 1'b0;
    eto_d    = 1'b0;
    if (bus.pic_mode) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.byte_data == SYNC_BYTE) begin
            state_d = ST_CMD;
            wbuf_d  = '0;
            idx_d   = '0;
          end
        end
        ST_CMD: begin
          wcmd_d  = bus.byte_data;
          sum_d   = bus.byte_data;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          sum_d = chk_add(sum_q, bus.byte_data);
          if (bus.byte_data > 8'(MAX_LEN)) begin
            elen_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wlen_d  = bus.byte_data[3:0];
            state_d = (bus.byte_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) wbuf_d[8*i +: 8] = bus.byte_data;
          end
          sum_d = chk_add(sum_q, bus.byte_data);
          idx_d = idx_q + 4'd1;
          if ((idx_q + 4'd1) == wlen_q) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.byte_data == sum_q) begin
            fcmd_d   = wcmd_q;
            flen_d   = wlen_q;
            fpay_d   = wbuf_q;
            fvalid_d = 1'b1;
          end else begin
            echk_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if ((state_q != ST_IDLE) && tmr_expired) begin
      eto_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    bus.busy          = (state_q != ST_IDLE);
    bus.frame_valid   = fvalid_q;
    bus.frame_cmd     = fcmd_q;
    bus.frame_len     = flen_q;
    bus.frame_payload = fpay_q;
    bus.err_chk       = echk_q;
    bus.err_len       = elen_q;
    bus.err_timeout   = eto_q;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected pulses are queued with their exact cycle.
module tb_uart_cmd_parser;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TIMEOUT = 20;

  typedef enum int {K_GOOD, K_CHK, K_LEN, K_TO} kind_e;
  typedef struct {
    kind_e                kind;
    int unsigned          at;
    logic [7:0]           cmd;
    logic [3:0]           len;
    logic [8*MAX_LEN-1:0] pay;
  } exp_t;

  logic clock_system = 1'b0;
  logic rstn = 1'b0;
  always #5 clock_system = ~clock_system;

  uart_cmd_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_cmd_parser #(
    .MAX_LEN   (MAX_LEN),
    .SYNC_BYTE (8'h55),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock_system (clock_system),
    .rstn         (rstn),
    .bus          (bus)
  );

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]           m_cmd = '0;
  logic [3:0]           m_len = '0;
  logic [8*MAX_LEN-1:0] m_pay = '0;

  always @(posedge clock_system) cyc++;

  task automatic monitor();
    int    npulse;
    kind_e okind;
    exp_t  e;
    forever begin
      @(negedge clock_system);
      if (rstn) begin
        if (sb.size() != 0 && cyc > sb[0].at) begin
          checks++; failures++;
          $display("FAIL missed_pulse kind=%0d expected at cycle %0d, none by cycle %0d",
                   int'(sb[0].kind), sb[0].at, cyc);
          e = sb.pop_front();
        end
        npulse = int'(bus.frame_valid) + int'(bus.err_chk) + int'(bus.err_len) + int'(bus.err_timeout);
        if (npulse > 1) begin
          checks++; failures++;
          $display("FAIL multi_pulse %0d pulses at cycle %0d, required at most 1", npulse, cyc);
        end else if (npulse == 1) begin
          okind = bus.frame_valid ? K_GOOD : bus.err_chk ? K_CHK : bus.err_len ? K_LEN : K_TO;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse kind=%0d at cycle %0d, required none", int'(okind), cyc);
          end else begin
            e = sb.pop_front();
            if (okind != e.kind || cyc != e.at) begin
              failures++;
              $display("FAIL pulse_kind_time got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                       int'(okind), cyc, int'(e.kind), e.at);
            end
            if (e.kind == K_GOOD) begin
              m_cmd = e.cmd;
              m_len = e.len;
              m_pay = e.pay;
            end
          end
          checks++;
          if (bus.frame_cmd !== m_cmd || bus.frame_len !== m_len || bus.frame_payload !== m_pay) begin
            failures++;
            $display("FAIL frame_outputs got cmd=%h len=%0d pay=%h, required cmd=%h len=%0d pay=%h",
                     bus.frame_cmd, bus.frame_len, bus.frame_payload, m_cmd, m_len, m_pay);
          end
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clock_system);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clock_system);
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic expect_ev(input kind_e k, input int unsigned at, input logic [7:0] cmd,
                           input logic [3:0] len, input logic [8*MAX_LEN-1:0] pay);
    exp_t e;
    e.kind = k; e.at = at; e.cmd = cmd; e.len = len; e.pay = pay;
    sb.push_back(e);
  endtask

  task automatic check_busy(input string name, input logic req);
    checks++;
    if (bus.busy !== req) begin
      failures++;
      $display("FAIL %s busy=%b, required %b", name, bus.busy, req);
    end
  endtask

  task automatic test_reset();
    logic [7:0] q[$];
    bus.pic_mode = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0;
    rstn = 1'b0;
    idle(3);
    rstn = 1'b1;
    check_busy("reset_busy", 1'b0);
    checks++;
    if ({bus.frame_valid, bus.err_chk, bus.err_len, bus.err_timeout} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses got %b, required 0000",
               {bus.frame_valid, bus.err_chk, bus.err_len, bus.err_timeout});
    end
    checks++;
    if (bus.frame_cmd !== 8'h00 || bus.frame_len !== 4'd0 || bus.frame_payload !== '0) begin
      failures++;
      $display("FAIL reset_frame got cmd=%h len=%0d pay=%h, required zeros",
               bus.frame_cmd, bus.frame_len, bus.frame_payload);
    end
    q = '{8'h55, 8'h10, 8'h02};
    send_seq(q);
    check_busy("midframe_busy", 1'b1);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(TIMEOUT + 4);
    check_busy("midframe_reset_busy", 1'b0);
  endtask

  task automatic test_good_frame();
    logic [7:0] q[$];
    q = '{8'h55, 8'h10, 8'h02, 8'hAA, 8'h01, 8'hBD};
    expect_ev(K_GOOD, cyc + 6, 8'h10, 4'd2, 64'h01AA);
    send_seq(q);
    idle(3);
    check_busy("good_busy", 1'b0);
    checks++;
    if (bus.frame_payload !== 64'h0000_0000_0000_01AA) begin
      failures++;
      $display("FAIL good_payload got %h, required 00000000000001aa", bus.frame_payload);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] q[$];
    q = '{8'h55, 8'h22, 8'h01, 8'h33, 8'hBE};
    expect_ev(K_CHK, cyc + 5, '0, '0, '0);
    send_seq(q);
    idle(3);
    checks++;
    if (bus.frame_cmd !== 8'h10 || bus.frame_len !== 4'd2) begin
      failures++;
      $display("FAIL chk_hold got cmd=%h len=%0d, required cmd=10 len=2", bus.frame_cmd, bus.frame_len);
    end
  endtask

  task automatic test_len_err();
    logic [7:0] q[$];
    q = '{8'h55, 8'h20, 8'h09};
    expect_ev(K_LEN, cyc + 3, '0, '0, '0);
    send_seq(q);
    check_busy("len_err_idle", 1'b0);
    q = '{8'h55, 8'h20, 8'h00, 8'h20};
    expect_ev(K_GOOD, cyc + 4, 8'h20, 4'd0, '0);
    send_seq(q);
    idle(3);
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    q = '{8'h55, 8'h10, 8'h02, 8'hAA};
    expect_ev(K_TO, cyc + 4 + TIMEOUT + 1, '0, '0, '0);
    send_seq(q);
    idle(TIMEOUT + 4);
    check_busy("timeout_busy", 1'b0);
    expect_ev(K_GOOD, cyc + 4 + TIMEOUT + 2, 8'h10, 4'd2, 64'h01AA);
    send_seq(q);
    idle(TIMEOUT);
    check_busy("timeout_edge_busy", 1'b1);
    send_byte(8'h01);
    send_byte(8'hBD);
    idle(3);
  endtask

  task automatic test_garbage_pic();
    logic [7:0] q[$];
    q = '{8'h00, 8'hFF};
    send_seq(q);
    check_busy("garbage_busy", 1'b0);
    q = '{8'h55, 8'h30, 8'h01, 8'h07, 8'h38};
    expect_ev(K_GOOD, cyc + 5, 8'h30, 4'd1, 64'h07);
    send_seq(q);
    q = '{8'h55, 8'h10, 8'h02};
    send_seq(q);
    bus.pic_mode = 1'b1;
    @(negedge clock_system);
    check_busy("pic_busy", 1'b0);
    q = '{8'hAA, 8'h01, 8'hBD, 8'h55};
    send_seq(q);
    check_busy("pic_ignore_busy", 1'b0);
    bus.pic_mode = 1'b0;
    idle(TIMEOUT + 5);
    check_busy("pic_after_busy", 1'b0);
    q = '{8'h55, 8'h31, 8'h00, 8'h31};
    expect_ev(K_GOOD, cyc + 4, 8'h31, 4'd0, '0);
    send_seq(q);
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [7:0]           q[$];
    logic [8*MAX_LEN-1:0] pay;
    q = '{8'h55, 8'h40, 8'h00, 8'h40, 8'h55, 8'h41, 8'h01, 8'h05, 8'h47,
          8'h55, 8'h50, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7C};
    for (int i = 0; i < int'(MAX_LEN); i++) pay[8*i +: 8] = 8'(i + 1);
    expect_ev(K_GOOD, cyc + 4,  8'h40, 4'd0, '0);
    expect_ev(K_GOOD, cyc + 9,  8'h41, 4'd1, 64'h05);
    expect_ev(K_GOOD, cyc + 21, 8'h50, 4'd8, pay);
    send_seq(q);
    idle(4);
    check_busy("b2b_busy", 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_garbage_pic();
    test_back_to_back();
    idle(5);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain %0d expected pulses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
